core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle sequencer for the single-issue RV32 datapath.
- Owns the 10-bit word PC and fetches instructions over a req/ack instruction-memory port.
- Presents the latched instruction to the combinational decoder and receives its control flags back.
- Steps through EXEC/MEM/WB with a one-cycle register write strobe, resolves BEQ/JAL next-PC, halts on ECALL, and faults on memory wait timeout.

Parameters:
- RESET_PC, 10'd0, word address loaded into PC on reset.
- WAIT_LIMIT, 15, maximum wait cycles for imem/dmem ack before fault (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins execution from current PC; honoured in IDLE only.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  10  equals pc.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  latched instruction driven to the decoder.
- alu_op_on, load_on, store_on, branch, jump  in  1 each  decoder flags for instr.
- alu_zero  in  1  ALU result==0, valid in EXEC.
- dmem_req  out  1  data access request; held until ack.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_ack  in  1  data access complete.
- reg_we  out  1  one-cycle register-file write strobe.
- pc  out  10  current word PC.
- busy  out  1  high in any state except IDLE, HALT and FAULT.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation) forces these values:
  - state=IDLE, pc=RESET_PC, instr=0, wait counter=0.
  - All outputs 0 except imem_addr=RESET_PC.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1.
  - imem_ack=1 -> instr<=imem_rdata, go to DECODE.
  - Otherwise the wait counter increments; reaching WAIT_LIMIT with no ack -> FAULT.
  - Ack arriving on the same cycle the counter reaches WAIT_LIMIT counts as success.
- DECODE: one cycle, lets the decoder settle.
  - instr==32'h00000073 (ECALL) -> HALT, pc unchanged.
  - Otherwise -> EXEC.
- EXEC: one cycle.
  - taken = branch & alu_zero.
  - load_on|store_on with jump=0 -> MEM; otherwise -> WB.
  - JAL is decoded with load_on=1 and jump=1; jump takes precedence, so JAL goes to WB.
- MEM:
  - dmem_req=1, dmem_we=store_on.
  - dmem_ack -> WB.
  - Same timeout rule as FETCH, using a shared counter that clears on each state entry.
- WB: one cycle.
  - reg_we=1 iff (alu_op_on|load_on|jump) and instr[11:7]!=0 (no x0 writes).
  - pc update:
    - jump=1: pc<=pc+J-imm[11:2].
    - taken=1: pc<=pc+B-imm[11:2].
    - otherwise: pc<=pc+1.
  - Immediates are sign-extended byte offsets; bits [11:2] are added as a word offset.
  - Arithmetic is modulo 1024; PC wraps 1023->0.
  - Next state: FETCH.
- Unrecognised opcodes (all decoder flags 0) execute as NOP: EXEC -> WB, no reg_we, pc+1.
- HALT and FAULT are sticky; the only exit is rst. start is ignored there.
- start outside IDLE is ignored. Acks outside their request state are ignored.
- Throughput: 4 cycles per ALU/branch/JAL instruction with zero-wait memory, 5 for load/store.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - DECODE checks opcode against {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1110011}.
  - Any other opcode -> FAULT; pc holds the offending address.
  - Also adds output illegal_op (1 bit), set together with fault and cleared only by rst.
- Undefined: no opcode check, unknown opcodes execute as NOP, no illegal_op port.

Test Plan:
- Reset then start; imem returns ADD x3,x1,x2 with ack in the first cycle:
  - imem_req high 1 cycle.
  - reg_we pulses exactly 4 cycles after start.
  - pc 0->1.
  - busy returns through FETCH.
- BEQ with offset +16 bytes at pc=5, alu_zero=1: pc->9. Same with alu_zero=0: pc->6, no reg_we.
- JAL x1,-8 at pc=0: reg_we=1, pc->1022 (wrap). Same with rd=x0: reg_we=0.
- Load with dmem_ack delayed 3 cycles:
  - dmem_req held 4 cycles, dmem_we=0.
  - WB follows ack.
  - Store variant: dmem_we=1, no reg_we.
- imem_ack never asserted: fault=1 after WAIT_LIMIT cycles, busy=0, later start ignored. ECALL: halted=1, pc frozen.
- Assert rst mid-MEM: outputs clear asynchronously and pc=RESET_PC. With SEQ_ILLEGAL_TRAP_EN, opcode 0x7F gives fault=1 and illegal_op=1.

Source files
------------

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
// Instruction- and data-memory handshake bundle for core_sequencer.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : 10-bit word address of the fetch (the sequencer PC)
//   imem_ack   : fetch data valid this cycle
//   imem_rdata : fetched instruction word
//   dmem_req   : data access request, held until dmem_ack
//   dmem_we    : 1 = store, 0 = load; valid with dmem_req
//   dmem_ack   : data access complete
// Modports: master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface core_sequencer_if;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle sequencer for a single-issue RV32 datapath. Owns the 10-bit word
// PC, fetches over a req/ack port, hands the latched instruction to an external
// combinational decoder, and walks FETCH/DECODE/EXEC/MEM/WB. BEQ/JAL next-PC is
// resolved in WB, ECALL halts, and a memory wait longer than WAIT_LIMIT faults.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start_i           : one-cycle pulse, begins execution (IDLE only)
//   mem_if            : imem/dmem handshake bundle (core_sequencer_if.master)
//   instr_o           : latched instruction driven to the decoder
//   alu_op_on_i, load_on_i, store_on_i, branch_i, jump_i : decoder flags
//   alu_zero_i        : ALU result == 0, sampled in EXEC
//   reg_we_o          : one-cycle register-file write strobe (WB)
//   pc_o              : current word PC
//   busy_o            : high in any state except IDLE, HALT, FAULT
//   halted_o, fault_o : sticky HALT / FAULT indications
//   illegal_op_o      : only with SEQ_ILLEGAL_TRAP_EN, set with an opcode fault
//
// Build option: define SEQ_ILLEGAL_TRAP_EN to fault on unsupported opcodes in
// DECODE; without it unknown opcodes execute as NOPs.
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter logic [9:0]  RESET_PC   = 10'd0,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  core_sequencer_if.master mem_if,
  output logic [31:0]  instr_o,
  input  logic         alu_op_on_i,
  input  logic         load_on_i,
  input  logic         store_on_i,
  input  logic         branch_i,
  input  logic         jump_i,
  input  logic         alu_zero_i,
  output logic         reg_we_o,
  output logic [9:0]   pc_o,
  output logic         busy_o,
  output logic         halted_o,
`ifdef SEQ_ILLEGAL_TRAP_EN
  output logic         illegal_op_o,
`endif
  output logic         fault_o
);

  localparam logic [7:0]  WaitLimit = 8'(WAIT_LIMIT);
  localparam logic [31:0] Ecall     = 32'h0000_0073;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StFault
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic        taken_q, taken_d;

  logic [7:0]  wait_inc;
  logic [9:0]  j_off, b_off;
  logic        imem_req, dmem_req, dmem_we, reg_we;

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1110011: opcode_legal = 1'b1;
      default:                            opcode_legal = 1'b0;
    endcase
  endfunction
`endif

  assign wait_inc = wait_q + 8'd1;

  // Word offsets are bits [11:2] of the byte immediates; higher bits vanish
  // in the modulo-1024 PC arithmetic.
  assign j_off = {instr_q[20], instr_q[30:22]};
  assign b_off = {instr_q[7], instr_q[30:25], instr_q[11:9]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      wait_q    <= '0;
      taken_q   <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      wait_q    <= wait_d;
      taken_q   <= taken_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    wait_d    = wait_q;
    taken_d   = taken_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        // Ack wins even on the cycle that would exhaust the wait budget.
        if (mem_if.imem_ack) begin
          instr_d = mem_if.imem_rdata;
          state_d = StDecode;
        end else if (wait_inc == WaitLimit) begin
          state_d = StFault;
        end else begin
          wait_d = wait_inc;
        end
      end
      StDecode: begin
        if (instr_q == Ecall) begin
          state_d = StHalt;
`ifdef SEQ_ILLEGAL_TRAP_EN
        end else if (!opcode_legal(instr_q[6:0])) begin
          state_d   = StFault;
          illegal_d = 1'b1;
`endif
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        taken_d = branch_i & alu_zero_i;
        // JAL also raises load_on; jump keeps it out of MEM.
        if ((load_on_i | store_on_i) && !jump_i) state_d = StMem;
        else                                     state_d = StWb;
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = store_on_i;
        if (mem_if.dmem_ack) begin
          state_d = StWb;
        end else if (wait_inc == WaitLimit) begin
          state_d = StFault;
        end else begin
          wait_d = wait_inc;
        end
      end
      StWb: begin
        reg_we = (alu_op_on_i | load_on_i | jump_i) && (instr_q[11:7] != 5'd0);
        if (jump_i)       pc_d = pc_q + j_off;
        else if (taken_q) pc_d = pc_q + b_off;
        else              pc_d = pc_q + 10'd1;
        state_d = StFetch;
      end
      StHalt, StFault: begin
        // Sticky until rst.
      end
      default: state_d = StIdle;
    endcase

    // The wait counter is shared by FETCH and MEM; every state entry restarts it.
    if (state_d != state_q) wait_d = '0;
  end

  assign mem_if.imem_req  = imem_req;
  assign mem_if.imem_addr = pc_q;
  assign mem_if.dmem_req  = dmem_req;
  assign mem_if.dmem_we   = dmem_we;

  assign instr_o  = instr_q;
  assign reg_we_o = reg_we;
  assign pc_o     = pc_q;
  assign busy_o   = !(state_q inside {StIdle, StHalt, StFault});
  assign halted_o = (state_q == StHalt);
  assign fault_o  = (state_q == StFault);
`ifdef SEQ_ILLEGAL_TRAP_EN
  assign illegal_op_o = illegal_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
// Drives core_sequencer as memory + decoder. A transaction-level model predicts
// the per-cycle outputs for each instruction (fetch waits, decode, exec, memory
// waits, write-back, PC update) and queues them; one compare process checks the
// DUT against that queue on every falling edge. Directed cases pin the model
// with literal values; a randomized program follows.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  localparam int WL     = 15;
  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MHalt  = 2;
  localparam int MFault = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        alu_zero;
  logic [31:0] instr;
  logic        reg_we;
  logic [9:0]  pc;
  logic        busy, halted, fault;
  logic [4:0]  flags;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  core_sequencer_if mem_if ();

  always #5 clk = ~clk;

  // Environment decoder: {alu_op_on, load_on, store_on, branch, jump}
  function automatic logic [4:0] dec(input logic [31:0] i);
    case (i[6:0])
      7'b0110011, 7'b0010011: return 5'b10000;
      7'b0000011:             return 5'b01000;
      7'b0100011:             return 5'b00100;
      7'b1100011:             return 5'b00010;
      7'b1101111:             return 5'b01001;
      default:                return 5'b00000;
    endcase
  endfunction

  assign flags = dec(instr);

  core_sequencer #(
    .RESET_PC   (10'd0),
    .WAIT_LIMIT (WL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .mem_if       (mem_if),
    .instr_o      (instr),
    .alu_op_on_i  (flags[4]),
    .load_on_i    (flags[3]),
    .store_on_i   (flags[2]),
    .branch_i     (flags[1]),
    .jump_i       (flags[0]),
    .alu_zero_i   (alu_zero),
    .reg_we_o     (reg_we),
    .pc_o         (pc),
    .busy_o       (busy),
    .halted_o     (halted),
`ifdef SEQ_ILLEGAL_TRAP_EN
    .illegal_op_o (illegal_op),
`endif
    .fault_o      (fault)
  );

  typedef struct {
    bit        ireq;
    bit [9:0]  iaddr;
    bit        dreq;
    bit        dwe;
    bit        rwe;
    bit [9:0]  pc;
    bit        busy;
    bit        halted;
    bit        fault;
    bit        ill;
    bit [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int ireq_cnt = 0;
  int dreq_cnt = 0;
  int rwe_cnt  = 0;

  // Model state
  int          m_pc;
  logic [31:0] m_instr;
  int          m_mode;
  bit          m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic exp_t base();
    exp_t e;
    e.ireq   = 1'b0;
    e.iaddr  = 10'(m_pc);
    e.dreq   = 1'b0;
    e.dwe    = 1'b0;
    e.rwe    = 1'b0;
    e.pc     = 10'(m_pc);
    e.busy   = 1'b0;
    e.halted = (m_mode == MHalt);
    e.fault  = (m_mode == MFault);
    e.ill    = m_ill;
    e.instr  = m_instr;
    return e;
  endfunction

  function automatic void model_reset();
    m_pc    = 0;
    m_instr = '0;
    m_mode  = MIdle;
    m_ill   = 1'b0;
  endfunction

  function automatic bit legal_op(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b1110011};
  endfunction

  // Compare process: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t ce;
    forever begin
      @(negedge clk);
      if (mem_if.imem_req) ireq_cnt++;
      if (mem_if.dmem_req) dreq_cnt++;
      if (reg_we) rwe_cnt++;
      if (exp_q.size() > 0) begin
        ce = exp_q.pop_front();
        chk("imem_req",  32'(mem_if.imem_req),  32'(ce.ireq));
        chk("imem_addr", 32'(mem_if.imem_addr), 32'(ce.iaddr));
        chk("dmem_req",  32'(mem_if.dmem_req),  32'(ce.dreq));
        if (ce.dreq) chk("dmem_we", 32'(mem_if.dmem_we), 32'(ce.dwe));
        chk("reg_we",    32'(reg_we),           32'(ce.rwe));
        chk("pc",        32'(pc),               32'(ce.pc));
        chk("busy",      32'(busy),             32'(ce.busy));
        chk("halted",    32'(halted),           32'(ce.halted));
        chk("fault",     32'(fault),            32'(ce.fault));
        chk("instr",     instr,                 ce.instr);
`ifdef SEQ_ILLEGAL_TRAP_EN
        chk("illegal_op", 32'(illegal_op),      32'(ce.ill));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input exp_t e, input bit st, input bit ia, input logic [31:0] rd,
                      input bit da, input bit az);
    @(posedge clk);
    #1;
    start              = st;
    mem_if.imem_ack    = ia;
    mem_if.imem_rdata  = rd;
    mem_if.dmem_ack    = da;
    alu_zero           = az;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst             = 1'b1;
    start           = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    model_reset();
    exp_q.push_back(base());
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(base());
  endtask

  task automatic do_start();
    step(base(), 1'b1, rb(), $urandom, rb(), rb());
    m_mode = MRun;
  endtask

  // smode: 0 start low, 1 random start, 2 start held high
  task automatic idle(input int n, input int smode);
    for (int k = 0; k < n; k++)
      step(base(), (smode == 2) ? 1'b1 : (smode == 1) ? rb() : 1'b0,
           rb(), $urandom, rb(), rb());
  endtask

  // Wait for the last queued cycle to be compared, then look one edge later.
  task automatic post();
    @(negedge clk);
    #1;
    start           = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int off, input int fd, input bit zr,
                           input int md, input int rst_at);
    exp_t       e;
    logic [4:0] f;
    bit         taken;
    int         i;
    i = 0;
    while (1) begin
      e = base(); e.ireq = 1'b1; e.busy = 1'b1;
      step(e, rb(), (i == fd), (i == fd) ? ins : $urandom, rb(), rb());
      if (i == fd) break;
      if (i + 1 == WL) begin m_mode = MFault; return; end
      i++;
    end
    m_instr = ins;
    e = base(); e.busy = 1'b1;
    step(e, rb(), rb(), $urandom, rb(), rb());
    if (ins == 32'h0000_0073) begin m_mode = MHalt; return; end
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (!legal_op(ins)) begin m_mode = MFault; m_ill = 1'b1; return; end
`endif
    f     = dec(ins);
    taken = f[1] & zr;
    e = base(); e.busy = 1'b1;
    step(e, rb(), rb(), $urandom, rb(), zr);
    if ((f[3] | f[2]) && !f[0]) begin
      i = 0;
      while (1) begin
        e = base(); e.busy = 1'b1; e.dreq = 1'b1; e.dwe = f[2];
        step(e, rb(), rb(), $urandom, (i == md), rb());
        if (i == rst_at) begin
          @(negedge clk);
          #2;
          rst = 1'b1;
          #1;
          chk("async_dmem_req", 32'(mem_if.dmem_req), 32'd0);
          chk("async_busy",     32'(busy),            32'd0);
          chk("async_pc",       32'(pc),              32'd0);
          chk("async_instr",    instr,                32'd0);
          model_reset();
          @(posedge clk);
          #1;
          rst             = 1'b0;
          start           = 1'b0;
          mem_if.imem_ack = 1'b0;
          mem_if.dmem_ack = 1'b0;
          return;
        end
        if (i == md) break;
        if (i + 1 == WL) begin m_mode = MFault; return; end
        i++;
      end
    end
    e = base(); e.busy = 1'b1;
    e.rwe = (f[4] | f[3] | f[0]) && (ins[11:7] != 5'd0);
    step(e, rb(), rb(), $urandom, rb(), rb());
    if (f[0])       m_pc = ((m_pc + (off >>> 2)) % 1024 + 1024) % 1024;
    else if (taken) m_pc = ((m_pc + (off >>> 2)) % 1024 + 1024) % 1024;
    else            m_pc = (m_pc + 1) % 1024;
  endtask

  function automatic logic [31:0] enc_r(input int rd);
    return {7'd0, 5'd2, 5'd1, 3'd0, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(input int rd);
    return {12'($urandom), 5'd1, 3'd0, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(input int rd);
    return {12'd4, 5'd1, 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw();
    return {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], 5'd2, 5'd1, 3'd0, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int rd, input int off);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'b1101111};
  endfunction

  localparam logic [31:0] Nop = 32'h0000_0013;

  initial begin
    logic [31:0] ins;
    int          off, kind, fd, md;

    rst               = 1'b1;
    start             = 1'b0;
    mem_if.imem_ack   = 1'b0;
    mem_if.imem_rdata = '0;
    mem_if.dmem_ack   = 1'b0;
    alu_zero          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_pc",        32'(pc),               32'd0);
    chk("reset_imem_addr", 32'(mem_if.imem_addr), 32'd0);
    chk("reset_busy",      32'(busy),             32'd0);
    chk("reset_instr",     instr,                 32'd0);

    // ADD x3,x1,x2 with zero-wait fetch
    do_reset();
    do_start();
    ireq_cnt = 0; rwe_cnt = 0;
    run_instr(32'h0020_81B3, 0, 0, 1'b0, 0, -1);
    post();
    chk("add_ireq_cycles", 32'(ireq_cnt), 32'd1);
    chk("add_reg_we",      32'(rwe_cnt),  32'd1);
    chk("add_pc",          32'(pc),       32'd1);
    chk("add_busy_fetch",  32'(busy),     32'd1);

    // BEQ +16 at pc=5, taken and not taken
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      do_start();
      repeat (5) run_instr(Nop, 0, 0, 1'b0, 0, -1);
      rwe_cnt = 0;
      run_instr(enc_b(16), 16, 0, 1'(z), 0, -1);
      post();
      chk(z ? "beq_taken_pc" : "beq_not_taken_pc", 32'(pc), z ? 32'd9 : 32'd6);
      chk("beq_reg_we", 32'(rwe_cnt), 32'd0);
    end

    // JAL -8 at pc=0, rd=x1 then rd=x0
    for (int r = 1; r >= 0; r--) begin
      do_reset();
      do_start();
      rwe_cnt = 0;
      run_instr(enc_j(r, -8), -8, 0, 1'b0, 0, -1);
      post();
      chk("jal_pc_wrap", 32'(pc),      32'd1022);
      chk("jal_reg_we",  32'(rwe_cnt), 32'(r));
    end

    // Load and store with dmem_ack 3 cycles late
    do_reset();
    do_start();
    dreq_cnt = 0; rwe_cnt = 0;
    run_instr(enc_lw(5), 0, 0, 1'b0, 3, -1);
    dreq_cnt = dreq_cnt; // counts settle at the WB compare below
    post();
    chk("load_dmem_req_cycles", 32'(dreq_cnt), 32'd4);
    chk("load_reg_we",          32'(rwe_cnt),  32'd1);
    do_reset();
    do_start();
    dreq_cnt = 0; rwe_cnt = 0;
    run_instr(enc_sw(), 0, 1, 1'b0, 3, -1);
    post();
    chk("store_dmem_req_cycles", 32'(dreq_cnt), 32'd4);
    chk("store_reg_we",          32'(rwe_cnt),  32'd0);

    // Fetch ack on the last permitted wait cycle still succeeds
    do_reset();
    do_start();
    ireq_cnt = 0;
    run_instr(Nop, 0, WL - 1, 1'b0, 0, -1);
    post();
    chk("fetch_edge_ireq_cycles", 32'(ireq_cnt), 32'(WL));
    chk("fetch_edge_no_fault",    32'(fault),    32'd0);

    // Fetch timeout: sticky fault, start ignored
    do_reset();
    do_start();
    ireq_cnt = 0;
    run_instr(Nop, 0, 1000, 1'b0, 0, -1);
    idle(4, 2);
    post();
    chk("timeout_ireq_cycles", 32'(ireq_cnt), 32'(WL));
    chk("timeout_fault",       32'(fault),    32'd1);
    chk("timeout_busy",        32'(busy),     32'd0);

    // ECALL halts with pc frozen
    do_reset();
    do_start();
    run_instr(Nop, 0, 0, 1'b0, 0, -1);
    run_instr(32'h0000_0073, 0, 2, 1'b0, 0, -1);
    idle(4, 2);
    post();
    chk("ecall_halted", 32'(halted), 32'd1);
    chk("ecall_pc",     32'(pc),     32'd1);

    // Reset in the middle of a load's MEM wait
    do_reset();
    do_start();
    run_instr(Nop, 0, 0, 1'b0, 0, -1);
    run_instr(enc_lw(7), 0, 0, 1'b0, 5, 2);
    idle(2, 0);

`ifdef SEQ_ILLEGAL_TRAP_EN
    do_reset();
    do_start();
    run_instr(Nop, 0, 0, 1'b0, 0, -1);
    run_instr(32'h0000_007F, 0, 0, 1'b0, 0, -1);
    idle(3, 1);
    post();
    chk("illegal_fault", 32'(fault),      32'd1);
    chk("illegal_flag",  32'(illegal_op), 32'd1);
    chk("illegal_pc",    32'(pc),         32'd1);
`endif

    // Randomized program
    do_reset();
    do_start();
    for (int n = 0; n < 250; n++) begin
      if (m_mode != MRun) begin
        idle(3, 1);
        do_reset();
        idle($urandom_range(0, 2), 0);
        do_start();
      end
      kind = $urandom_range(0, 99);
      off  = 0;
      if (kind < 25)      ins = enc_r($urandom_range(0, 31));
      else if (kind < 40) ins = enc_addi($urandom_range(0, 31));
      else if (kind < 50) ins = enc_lw($urandom_range(0, 31));
      else if (kind < 60) ins = enc_sw();
      else if (kind < 75) begin
        off = (int'($urandom_range(0, 4095)) - 2048) * 2;
        ins = enc_b(off);
      end else if (kind < 85) begin
        off = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
        ins = enc_j($urandom_range(0, 31), off);
      end else if (kind < 92) begin
        ins = {25'($urandom), 7'b0001011};
      end else if (kind < 95) begin
        ins = 32'h0000_0073;
      end else begin
        ins = enc_r(0);
      end
      fd = $urandom_range(0, 99);
      fd = (fd < 2) ? WL + 3 : (fd < 5) ? WL - 1 : $urandom_range(0, 3);
      md = $urandom_range(0, 99);
      md = (md < 2) ? WL + 3 : (md < 5) ? WL - 1 : $urandom_range(0, 3);
      run_instr(ins, off, fd, rb(), md, -1);
    end
    post();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
